// File: rtl/tensorcore_seq_pkg.sv
// Shared types and constants for the tensor-core sequencer.
// Covers the operand type, the sequencer states and the request selects.
package tensorcore_seq_pkg;

  typedef enum logic [1:0] {
    INT4 = 2'd0,
    INT8 = 2'd1,
    FP16 = 2'd2,
    FP32 = 2'd3
  } type_t;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_C,
    LOAD_A,
    LOAD_B,
    SYSTOLIC,
    ACCUMULATE,
    WAIT_WRITE,
    WRITE_BACK,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_REQ,
    HS_WAIT
  } hs_phase_t;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_A    = 3'b100;
  localparam logic [2:0] SEL_B    = 3'b010;
  localparam logic [2:0] SEL_C    = 3'b001;

  function automatic logic [2:0] sel_of(state_t s);
    case (s)
      LOAD_A:             return SEL_A;
      LOAD_B:             return SEL_B;
      LOAD_C, WRITE_BACK: return SEL_C;
      default:            return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tensorcore_seq_xfer_hs.sv
// REQ/WAIT handshake tracker shared by every load and store state.
// It raises req_valid until accepted, then waits for the completion pulse.
module xfer_hs import tensorcore_seq_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic req_ready,
  input  logic xfer_done,
  input  logic abort,
  output logic req_valid,
  output logic complete,
  output logic proto_err
);

  hs_phase_t phase;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      phase <= HS_IDLE;
    end else begin
      case (phase)
        HS_IDLE: if (go)        phase <= HS_REQ;
        HS_REQ:  if (req_ready) phase <= HS_WAIT;
        HS_WAIT: if (xfer_done) phase <= HS_IDLE;
        default:                phase <= HS_IDLE;
      endcase
    end
  end

  assign req_valid = (phase == HS_REQ);
  // complete is combinational so the owning state leaves on the cycle after xfer_done
  assign complete  = (phase == HS_WAIT) && xfer_done && !abort;
  assign proto_err = (phase == HS_REQ)  && xfer_done && !abort;

endmodule

// File: rtl/tensorcore_seq.sv
// Top-level sequencer: C preload, per-tile A/B load, systolic run and
// INT4 accumulate, then result drain and C write-back.
module tensorcore_seq import tensorcore_seq_pkg::*; #(
  parameter int L     = 8,
  parameter int CNT_W = 16,
  parameter int KT_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [1:0]      cfg_dtype,
  input  logic [KT_W-1:0] cfg_k_tiles,
  input  logic            cfg_load_c,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [2:0]      req_sel,
  output logic            req_write,
  output logic [KT_W-1:0] req_tile,
  input  logic            xfer_done,
  output logic            sys_en,
  output logic            acc_en,
  output logic            wb_en,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(3 * L - 3);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(L - 1);

  if ($clog2(3 * L - 1) > CNT_W) begin : g_cnt_width_check
    $error("tensorcore_seq: CNT_W cannot hold the 3L-2 run length");
  end

  state_t          state;
  state_t          nxt;
  logic [CNT_W-1:0] cnt;
  logic [KT_W-1:0] tile;
  logic [KT_W-1:0] k_tiles_q;
  type_t           dtype_q;
  logic            load_c_q;
  logic            go;
  logic            complete;
  logic            proto_err;
  logic            last_tile;

  assign go        = state inside {LOAD_C, LOAD_A, LOAD_B, WRITE_BACK};
  assign last_tile = (tile == k_tiles_q - KT_W'(1));
  assign req_tile  = tile;

  xfer_hs u_hs (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .req_ready (req_ready),
    .xfer_done (xfer_done),
    .abort     (abort),
    .req_valid (req_valid),
    .complete  (complete),
    .proto_err (proto_err)
  );

  always_comb begin
    nxt = state;
    if (state == IDLE) begin
      if (start && !abort && cfg_k_tiles != '0)
        nxt = cfg_load_c ? LOAD_C : LOAD_A;
    end else if (abort) begin
      nxt = IDLE;
    end else begin
      case (state)
        LOAD_C:     if (complete) nxt = LOAD_A;
        LOAD_A:     if (complete) nxt = LOAD_B;
        LOAD_B:     if (complete) nxt = SYSTOLIC;
        SYSTOLIC:
          if (cnt == '0) begin
            if (dtype_q == INT4) nxt = ACCUMULATE;
            else                 nxt = last_tile ? WAIT_WRITE : LOAD_A;
          end
        ACCUMULATE: nxt = last_tile ? WAIT_WRITE : LOAD_A;
        WAIT_WRITE: if (cnt == '0) nxt = WRITE_BACK;
        WRITE_BACK: if (complete) nxt = DONE;
        DONE:       nxt = IDLE;
        default:    nxt = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      tile      <= '0;
      k_tiles_q <= '0;
      dtype_q   <= INT4;
      load_c_q  <= 1'b0;
      err       <= 1'b0;
      req_sel   <= SEL_NONE;
      req_write <= 1'b0;
      sys_en    <= 1'b0;
      acc_en    <= 1'b0;
      wb_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= nxt;

      if (state == IDLE && start && !abort) begin
        k_tiles_q <= cfg_k_tiles;
        dtype_q   <= type_t'(cfg_dtype);
        load_c_q  <= cfg_load_c;
        err       <= (cfg_k_tiles == '0);
      end else if (proto_err) begin
        err <= 1'b1;
      end

      if (nxt == IDLE)
        cnt <= '0;
      else if (nxt == SYSTOLIC && state != SYSTOLIC)
        cnt <= RUN_LAST;
      else if (nxt == WAIT_WRITE && state != WAIT_WRITE)
        cnt <= DRAIN_LAST;
      else if (cnt != '0)
        cnt <= cnt - CNT_W'(1);

      if (nxt == IDLE)
        tile <= '0;
      else if (nxt == LOAD_A && (state == SYSTOLIC || state == ACCUMULATE))
        tile <= tile + KT_W'(1);

      req_sel   <= sel_of(nxt);
      req_write <= (nxt == WRITE_BACK);
      sys_en    <= (nxt == SYSTOLIC);
      acc_en    <= (nxt == ACCUMULATE);
      wb_en     <= (nxt == WAIT_WRITE);
      busy      <= (nxt != IDLE);
      done      <= (nxt == DONE);
    end
  end

endmodule

// File: tb/tb_tensorcore_seq.sv
// Self-checking bench for tensorcore_seq with a reactive front-end model.
`timescale 1ns/1ps
module tb_tensorcore_seq;

  localparam int TB_L = 8;
  localparam int KW   = 8;
  localparam int RUN  = 3 * TB_L - 2;
  localparam logic [1:0] T_INT4 = 2'd0;
  localparam logic [1:0] T_INT8 = 2'd1;
  localparam logic [1:0] T_FP16 = 2'd2;
  localparam logic [1:0] T_FP32 = 2'd3;

  logic clk = 1'b0;
  logic rst, start, abort, cfg_load_c, req_ready, xfer_done;
  logic req_valid, req_write, sys_en, acc_en, wb_en, busy, done, err;
  logic [1:0]    cfg_dtype;
  logic [KW-1:0] cfg_k_tiles, req_tile;
  logic [2:0]    req_sel;

  tensorcore_seq #(.L(TB_L), .CNT_W(16), .KT_W(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_dtype(cfg_dtype), .cfg_k_tiles(cfg_k_tiles), .cfg_load_c(cfg_load_c),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_write(req_write), .req_tile(req_tile), .xfer_done(xfer_done),
    .sys_en(sys_en), .acc_en(acc_en), .wb_en(wb_en), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // front-end model knobs and state
  bit fe_auto = 1'b1;
  int stall_cycles = 0, stall_left = 0, done_lat = 3, lat_cnt = 0;
  logic [11:0] req_log[$];
  logic [11:0] exp_log[$];

  // monitor statistics
  int sys_cycles, sys_run, last_run, win_cnt, bad_win;
  int acc_pulses, acc_ok, wb_cycles, done_cnt, busy_bad, excl_viol;
  bit prev_sys, prev_done;

  initial begin
    req_ready = 1'b0;
    xfer_done = 1'b0;
    forever begin
      @(negedge clk);
      xfer_done = 1'b0;
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) xfer_done = 1'b1;
      end
      req_ready = 1'b0;
      if (fe_auto && req_valid) begin
        if (stall_left > 0) stall_left--;
        else begin
          req_ready = 1'b1;
          req_log.push_back({req_write, req_sel, req_tile});
          lat_cnt    = done_lat;
          stall_left = stall_cycles;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (sys_en) begin
        sys_cycles++;
        sys_run++;
      end else if (prev_sys) begin
        last_run = sys_run;
        win_cnt++;
        if (sys_run != RUN) bad_win++;
        sys_run = 0;
      end
      if (acc_en) begin
        acc_pulses++;
        if (prev_sys && last_run == RUN) acc_ok++;
      end
      if (wb_en) wb_cycles++;
      if (done) done_cnt++;
      if (prev_done && busy) busy_bad++;
      if (int'(sys_en) + int'(acc_en) + int'(wb_en) > 1) excl_viol++;
      prev_sys  = sys_en;
      prev_done = done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic clear_stats();
    sys_cycles = 0; sys_run = 0; last_run = 0; win_cnt = 0; bad_win = 0;
    acc_pulses = 0; acc_ok = 0; wb_cycles = 0; done_cnt = 0; busy_bad = 0;
    excl_viol = 0; prev_sys = 0; prev_done = 0;
    req_log.delete();
    stall_left = stall_cycles;
  endtask

  // Reference request order: optional C, then A,B per tile, then the C store.
  task automatic build_expected(input bit load_c, input int k);
    exp_log.delete();
    if (load_c) exp_log.push_back({1'b0, 3'b001, 8'd0});
    for (int t = 0; t < k; t++) begin
      exp_log.push_back({1'b0, 3'b100, 8'(t)});
      exp_log.push_back({1'b0, 3'b010, 8'(t)});
    end
    exp_log.push_back({1'b1, 3'b001, 8'(k - 1)});
  endtask

  function automatic int log_diff();
    if (req_log.size() != exp_log.size()) return -2;
    foreach (exp_log[i]) if (req_log[i] !== exp_log[i]) return i;
    return -1;
  endfunction

  task automatic start_op(input logic [1:0] dt, input int k, input bit lc);
    @(negedge clk);
    cfg_dtype = dt; cfg_k_tiles = KW'(k); cfg_load_c = lc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_dtype = 2'($urandom); cfg_k_tiles = '0; cfg_load_c = 1'($urandom);
  endtask

  task automatic wait_done(output bit to);
    to = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (done_cnt > 0) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [18:0] v;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_dtype = '0; cfg_k_tiles = '0; cfg_load_c = 1'b0;
    repeat (3) @(negedge clk);
    v = {req_valid, req_sel, req_write, req_tile, sys_en, acc_en, wb_en, busy, done, err};
    checks++;
    if (v !== 19'd0) begin errors++; $display("FAIL reset_during: got %h expected 0", v); end
    rst = 1'b0;
    @(negedge clk);
    v = {req_valid, req_sel, req_write, req_tile, sys_en, acc_en, wb_en, busy, done, err};
    checks++;
    if (v !== 19'd0) begin errors++; $display("FAIL reset_after: got %h expected 0", v); end
  endtask

  task automatic test_fp16_single();
    bit to;
    int d;
    stall_cycles = 0; done_lat = 3;
    clear_stats();
    build_expected(1'b1, 1);
    start_op(T_FP16, 1, 1'b1);
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL t1_timeout: got timeout expected done"); end
    d = log_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL t1_req_log: diff %0d got %0d reqs expected %0d", d, req_log.size(), exp_log.size()); end
    checks++; if (sys_cycles != RUN || win_cnt != 1) begin errors++; $display("FAIL t1_sys_en: got %0d cycles/%0d windows expected %0d/1", sys_cycles, win_cnt, RUN); end
    checks++; if (wb_cycles != TB_L) begin errors++; $display("FAIL t1_wb_en: got %0d expected %0d", wb_cycles, TB_L); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL t1_done_count: got %0d expected 1", done_cnt); end
    checks++; if (busy_bad != 0 || busy !== 1'b0) begin errors++; $display("FAIL t1_busy_after_done: got %0d expected 0", busy_bad); end
    checks++; if (acc_pulses != 0) begin errors++; $display("FAIL t1_acc_en: got %0d expected 0", acc_pulses); end
    checks++; if (err !== 1'b0 || excl_viol != 0) begin errors++; $display("FAIL t1_err_excl: got err=%b excl=%0d expected 0/0", err, excl_viol); end
  endtask

  task automatic test_int4_multi();
    bit to;
    int d;
    stall_cycles = 0; done_lat = 2;
    clear_stats();
    build_expected(1'b0, 3);
    start_op(T_INT4, 3, 1'b0);
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL t2_timeout: got timeout expected done"); end
    d = log_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL t2_req_log: diff %0d got %0d reqs expected %0d", d, req_log.size(), exp_log.size()); end
    checks++; if (acc_pulses != 3) begin errors++; $display("FAIL t2_acc_count: got %0d expected 3", acc_pulses); end
    checks++; if (acc_ok != 3) begin errors++; $display("FAIL t2_acc_after_sys: got %0d expected 3", acc_ok); end
    checks++; if (win_cnt != 3 || bad_win != 0) begin errors++; $display("FAIL t2_sys_windows: got %0d windows %0d bad expected 3/0", win_cnt, bad_win); end
    checks++; if (wb_cycles != TB_L || done_cnt != 1) begin errors++; $display("FAIL t2_wb_done: got %0d/%0d expected %0d/1", wb_cycles, done_cnt, TB_L); end
  endtask

  task automatic test_ready_stall();
    bit to, seen;
    int d;
    stall_cycles = 5; done_lat = 3;
    clear_stats();
    build_expected(1'b0, 1);
    start_op(T_FP32, 1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (req_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL t3_valid_timeout: got no req_valid expected req_valid"); end
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (req_valid !== 1'b1 || req_sel !== 3'b100 || req_tile !== 8'd0) begin
        errors++;
        $display("FAIL t3_hold_c%0d: got valid=%b sel=%b tile=%0d expected 1/100/0", c, req_valid, req_sel, req_tile);
      end
      @(negedge clk);
    end
    checks++;
    if (req_valid !== 1'b0 || req_sel !== 3'b100 || sys_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL t3_wait_phase: got valid=%b sel=%b sys=%b busy=%b expected 0/100/0/1", req_valid, req_sel, sys_en, busy);
    end
    wait_done(to);
    d = log_diff();
    checks++; if (to || d != -1) begin errors++; $display("FAIL t3_complete: got to=%b diff=%0d expected 0/-1", to, d); end
    stall_cycles = 0;
  endtask

  task automatic test_abort();
    bit to, seen;
    int d;
    stall_cycles = 0; done_lat = 3;
    clear_stats();
    start_op(T_FP16, 2, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sys_en) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL t4_sys_timeout: got no sys_en expected sys_en"); end
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (sys_en !== 1'b0 || busy !== 1'b0 || req_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL t4_abort_outputs: got sys=%b busy=%b valid=%b done=%b expected 0", sys_en, busy, req_valid, done);
    end
    repeat (10) @(negedge clk);
    checks++; if (done_cnt != 0 || busy !== 1'b0) begin errors++; $display("FAIL t4_no_done: got done=%0d busy=%b expected 0/0", done_cnt, busy); end
    #1 xfer_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0 || err !== 1'b0 || req_valid !== 1'b0) begin errors++; $display("FAIL t4_late_done: got busy=%b err=%b valid=%b expected 0", busy, err, req_valid); end

    done_lat = 6;
    clear_stats();
    start_op(T_FP32, 1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (req_log.size() != 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || err !== 1'b0 || req_log.size() != 1) begin
      errors++;
      $display("FAIL t4_abandon_xfer: got busy=%b err=%b reqs=%0d expected 0/0/1", busy, err, req_log.size());
    end

    @(negedge clk);
    cfg_dtype = T_FP16; cfg_k_tiles = 8'd1; cfg_load_c = 1'b0;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || req_valid !== 1'b0) begin errors++; $display("FAIL t4_abort_wins: got busy=%b valid=%b expected 0/0", busy, req_valid); end

    done_lat = 3;
    clear_stats();
    build_expected(1'b0, 1);
    start_op(T_INT8, 1, 1'b0);
    wait_done(to);
    d = log_diff();
    checks++;
    if (to || d != -1 || done_cnt != 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL t4_restart: got to=%b diff=%0d done=%0d err=%b expected 0/-1/1/0", to, d, done_cnt, err);
    end
  endtask

  task automatic test_zero_tiles();
    bit to;
    int bad;
    clear_stats();
    @(negedge clk);
    cfg_dtype = T_FP16; cfg_k_tiles = '0; cfg_load_c = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (err !== 1'b1 || busy !== 1'b0 || req_valid !== 1'b0) begin errors++; $display("FAIL t5_zero_err: got err=%b busy=%b valid=%b expected 1/0/0", err, busy, req_valid); end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (req_valid || busy) bad++;
    end
    checks++; if (bad != 0 || err !== 1'b1) begin errors++; $display("FAIL t5_zero_idle: got bad=%0d err=%b expected 0/1", bad, err); end
    start_op(T_FP16, 1, 1'b0);
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL t5_err_clear: got err=%b busy=%b expected 0/1", err, busy); end
    wait_done(to);
    checks++; if (to || done_cnt != 1) begin errors++; $display("FAIL t5_run: got to=%b done=%0d expected 0/1", to, done_cnt); end
  endtask

  task automatic test_proto_err_rst();
    bit seen;
    int bad;
    logic [18:0] v;
    stall_cycles = 20; done_lat = 3;
    clear_stats();
    start_op(T_FP32, 1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (req_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL t6_valid_timeout: got no req_valid expected req_valid"); end
    #1 xfer_done = 1'b1;
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || req_valid !== 1'b1 || req_sel !== 3'b100 || busy !== 1'b1) begin
      errors++;
      $display("FAIL t6_proto_err: got err=%b valid=%b sel=%b busy=%b expected 1/1/100/1", err, req_valid, req_sel, busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (wb_en) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL t6_wb_timeout: got no wb_en expected wb_en"); end
    rst = 1'b1;
    @(negedge clk);
    v = {req_valid, req_sel, req_write, req_tile, sys_en, acc_en, wb_en, busy, done, err};
    checks++; if (v !== 19'd0) begin errors++; $display("FAIL t6_rst_outputs: got %h expected 0", v); end
    rst = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (req_valid || busy || done) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL t6_rst_quiet: got %0d active cycles expected 0", bad); end
    stall_cycles = 0;
    stall_left   = 0;
  endtask

  task automatic test_random();
    bit to, lc;
    int d, k, exp_acc;
    logic [1:0] dt;
    for (int it = 0; it < 6; it++) begin
      dt = 2'($urandom_range(0, 3));
      k  = $urandom_range(1, 4);
      lc = 1'($urandom_range(0, 1));
      done_lat     = $urandom_range(1, 4);
      stall_cycles = $urandom_range(0, 2);
      exp_acc = (dt == T_INT4) ? k : 0;
      clear_stats();
      build_expected(lc, k);
      start_op(dt, k, lc);
      wait_done(to);
      d = log_diff();
      checks++; if (to) begin errors++; $display("FAIL rnd%0d_timeout: got timeout expected done", it); end
      checks++; if (d != -1) begin errors++; $display("FAIL rnd%0d_req_log: diff %0d got %0d reqs expected %0d", it, d, req_log.size(), exp_log.size()); end
      checks++; if (sys_cycles != RUN * k || win_cnt != k || bad_win != 0) begin errors++; $display("FAIL rnd%0d_sys: got %0d cycles %0d windows expected %0d/%0d", it, sys_cycles, win_cnt, RUN * k, k); end
      checks++; if (acc_pulses != exp_acc || acc_ok != exp_acc) begin errors++; $display("FAIL rnd%0d_acc: got %0d/%0d expected %0d", it, acc_pulses, acc_ok, exp_acc); end
      checks++; if (wb_cycles != TB_L || done_cnt != 1) begin errors++; $display("FAIL rnd%0d_wb_done: got %0d/%0d expected %0d/1", it, wb_cycles, done_cnt, TB_L); end
      checks++; if (err !== 1'b0 || excl_viol != 0 || busy_bad != 0) begin errors++; $display("FAIL rnd%0d_flags: got err=%b excl=%0d busy_bad=%0d expected 0", it, err, excl_viol, busy_bad); end
    end
    stall_cycles = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_dtype = '0; cfg_k_tiles = '0; cfg_load_c = 1'b0;
    test_reset();
    test_fp16_single();
    test_int4_multi();
    test_ready_stall();
    test_abort();
    test_zero_tiles();
    test_proto_err_rst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
